// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store sequencer: access size encodings,
// FSM state type and default memory-window parameters.
package mem_access_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

  // Highest valid word index (byte 0x7FFFFFFC) and number of implemented words.
  localparam logic [29:0]  DEF_MEM_TOP_WORD = 30'h1FFFFFFF;
  localparam int unsigned  DEF_MEM_DEPTH    = 2049;

endpackage

// File: rtl/subword_lane.sv
// Combinational lane logic for sub-word accesses on a little-endian word.
//   size      : access size (SIZE_WORD / SIZE_HALF / SIZE_BYTE)
//   offset    : byte address bits [1:0]
//   sign_ext  : replicate lane MSB on loads when set
//   rdata     : word read from memory
//   wdata     : low 16 bits of store data
//   load_data : addressed lane, extended to 32 bits (word passes through)
//   merge_data: rdata with only the addressed lane replaced by wdata
module subword_lane
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default:   load_data = rdata;
    endcase

    merge_data = rdata;
    case (size)
      SIZE_BYTE: merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (offset[1]) merge_data[31:16] = wdata;
        else           merge_data[15:0]  = wdata;
      end
      default: merge_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM-stage request and a word-wide data
// memory. Sub-word stores use read-modify-write; sub-word loads extract and
// extend the addressed lane. Misaligned, illegal-size and out-of-range
// requests complete with respErr and never reach memory.
//   clk, rst_n          : clock, asynchronous active-low reset
//   reqValid/reqReady   : request handshake (ready only in IDLE)
//   reqWrite/reqSize/reqSigned/reqAddr/reqWdata : request fields
//   respValid/respData/respErr : one-cycle completion pulse and result
//   memRead/memWrite/memAddr/memWdata/memRdata  : data memory interface
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [29:0] MEM_TOP_WORD = DEF_MEM_TOP_WORD,
  parameter int unsigned MEM_DEPTH    = DEF_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata
);

  localparam logic [29:0] MEM_LOW_WORD = MEM_TOP_WORD - 30'(MEM_DEPTH - 1);

  state_t      state, next_state;
  logic        accept;
  logic        req_err;
  logic [29:0] word_idx;

  logic        write_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;

  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign reqReady = (state == ST_IDLE);
  assign word_idx = reqAddr[31:2];

  always_comb begin
    req_err = 1'b0;
    case (reqSize)
      SIZE_WORD: req_err = (reqAddr[1:0] != 2'b00);
      SIZE_HALF: req_err = reqAddr[0];
      SIZE_BYTE: req_err = 1'b0;
      default:   req_err = 1'b1;
    endcase
    if ((word_idx > MEM_TOP_WORD) || (word_idx < MEM_LOW_WORD)) req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reqValid) begin
          accept = 1'b1;
          if (req_err)                               next_state = ST_DONE;
          else if (reqWrite && reqSize == SIZE_WORD) next_state = ST_WR;
          else                                       next_state = ST_RD;
        end
      end
      ST_RD:   next_state = ST_CAP;
      ST_CAP:  next_state = write_q ? ST_WR : ST_DONE;
      ST_WR:   next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  subword_lane u_lane (
    .size       (size_q),
    .offset     (offset_q),
    .sign_ext   (sign_q),
    .rdata      (memRdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Strobes are registered from next_state so each is high for exactly the
  // cycle the FSM spends in the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      respValid <= 1'b0;
      respErr   <= 1'b0;
      respData  <= '0;
      memAddr   <= '0;
      memWdata  <= '0;
      write_q   <= 1'b0;
      size_q    <= SIZE_WORD;
      sign_q    <= 1'b0;
      offset_q  <= '0;
      wdata_q   <= '0;
    end else begin
      memRead   <= (next_state == ST_RD);
      memWrite  <= (next_state == ST_WR);
      respValid <= (next_state == ST_DONE);

      if (accept) begin
        write_q  <= reqWrite;
        size_q   <= reqSize;
        sign_q   <= reqSigned;
        offset_q <= reqAddr[1:0];
        wdata_q  <= reqWdata[15:0];
        memAddr  <= {reqAddr[31:2], 2'b00};
        if (reqWrite && reqSize == SIZE_WORD) memWdata <= reqWdata;
      end

      if (state == ST_CAP && write_q) memWdata <= merge_data;

      // DONE is entered straight from IDLE only on a rejected request.
      if (next_state == ST_DONE) begin
        respErr  <= (state == ST_IDLE);
        respData <= (state == ST_CAP && !write_q) ? load_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'd0;
  logic        reqSigned = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        respValid;
  logic [31:0] respData;
  logic        respErr;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    int          t0;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [logic [29:0]];

  mem_access_unit #(
    .MEM_TOP_WORD (30'h1FFFFFFF),
    .MEM_DEPTH    (2049)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqWrite  (reqWrite),
    .reqSize   (reqSize),
    .reqSigned (reqSigned),
    .reqAddr   (reqAddr),
    .reqWdata  (reqWdata),
    .respValid (respValid),
    .respData  (respData),
    .respErr   (respErr),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .memAddr   (memAddr),
    .memWdata  (memWdata),
    .memRdata  (memRdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [29:0] idx);
    if (mem.exists(idx)) return mem[idx];
    return '0;
  endfunction

  // Memory: samples read on posedge (data next cycle), writes on negedge.
  always @(posedge clk) if (memRead) memRdata <= mem_rd(memAddr[31:2]);

  initial forever begin
    @(negedge clk);
    if (memWrite) mem[memAddr[31:2]] = memWdata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: counts memory strobes per transaction and scores each response.
  initial begin
    int rd_cnt;
    int wr_cnt;
    exp_t e;
    rd_cnt = 0;
    wr_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (memRead)  rd_cnt++;
        if (memWrite) wr_cnt++;
        if (respValid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=respValid expected=none data=0x%08h", respData);
          end else begin
            e = sb.pop_front();
            check("resp_data", respData, e.data);
            check("resp_err", 32'(respErr), 32'(e.err));
            check("latency", 32'(cyc - e.t0), 32'(e.lat));
            check("mem_read_cycles", 32'(rd_cnt), 32'(e.rd));
            check("mem_write_cycles", 32'(wr_cnt), 32'(e.wr));
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input int el,
                       input int er, input int ew, input bit hold);
    exp_t e;
    int n;
    n = 0;
    while (!reqReady && n < 20) begin @(negedge clk); n++; end
    if (!reqReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
      return;
    end
    reqValid  = 1'b1;
    reqWrite  = w;
    reqSize   = sz;
    reqSigned = sg;
    reqAddr   = a;
    reqWdata  = wd;
    e.data = ed;
    e.err  = ee;
    e.lat  = el;
    e.rd   = er;
    e.wr   = ew;
    e.t0   = cyc;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    if (hold) begin
      n = 0;
      while (!respValid && n < 20) begin @(negedge clk); n++; end
    end
    reqValid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=none expected=respValid");
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    mem[30'h1FFFFFFC] = 32'h80FF3344;
    mem[30'h1FFFFFFF] = 32'h01020304;
    mem[30'h1FFFF7FF] = 32'hCAFEF00D;

    repeat (3) @(negedge clk);
    check("rst_reqReady", 32'(reqReady), 32'd1);
    check("rst_respValid", 32'(respValid), 32'd0);
    check("rst_memRead", 32'(memRead), 32'd0);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_respData", respData, 32'h0);
    check("rst_respErr", 32'(respErr), 32'd0);
    check("rst_memAddr", memAddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads on the preloaded word 0x80FF3344
    issue(0, SIZE_BYTE, 1, 32'h7FFFFFF3, '0, 32'hFFFFFF80, 0, 3, 1, 0, 0);
    issue(0, SIZE_BYTE, 0, 32'h7FFFFFF3, '0, 32'h00000080, 0, 3, 1, 0, 0);
    issue(0, SIZE_BYTE, 1, 32'h7FFFFFF2, '0, 32'hFFFFFFFF, 0, 3, 1, 0, 0);
    issue(0, SIZE_BYTE, 0, 32'h7FFFFFF1, '0, 32'h00000033, 0, 3, 1, 0, 0);
    issue(0, SIZE_HALF, 1, 32'h7FFFFFF2, '0, 32'hFFFF80FF, 0, 3, 1, 0, 0);
    issue(0, SIZE_HALF, 1, 32'h7FFFFFF0, '0, 32'h00003344, 0, 3, 1, 0, 0);
    issue(0, SIZE_WORD, 0, 32'h7FFFFFF0, '0, 32'h80FF3344, 0, 3, 1, 0, 0);
    // Range boundaries
    issue(0, SIZE_WORD, 0, 32'h7FFFFFFC, '0, 32'h01020304, 0, 3, 1, 0, 0);
    issue(0, SIZE_WORD, 0, 32'h7FFFDFFC, '0, 32'hCAFEF00D, 0, 3, 1, 0, 0);
    issue(0, SIZE_WORD, 0, 32'h7FFFDFF8, '0, 32'h0, 1, 1, 0, 0, 0);
    issue(0, SIZE_WORD, 0, 32'h80000000, '0, 32'h0, 1, 1, 0, 0, 0);

    // Error cases
    issue(1, SIZE_WORD, 0, 32'h7FFFFFF1, 32'h11223344, 32'h0, 1, 1, 0, 0, 0);
    check("sw_misaligned_word_kept", mem_rd(30'h1FFFFFFC), 32'h80FF3344);
    issue(1, SIZE_HALF, 0, 32'h7FFFFFF1, 32'h11223344, 32'h0, 1, 1, 0, 0, 0);
    issue(0, SIZE_WORD, 0, 32'h00001000, '0, 32'h0, 1, 1, 0, 0, 0);
    issue(0, 2'd3, 0, 32'h7FFFFFF0, '0, 32'h0, 1, 1, 0, 0, 0);
    check("err_word_kept", mem_rd(30'h1FFFFFFC), 32'h80FF3344);

    // Reset during CAP of a byte store
    reqValid  = 1'b1;
    reqWrite  = 1'b1;
    reqSize   = SIZE_BYTE;
    reqSigned = 1'b0;
    reqAddr   = 32'h7FFFFFF0;
    reqWdata  = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    check("abort_rd_issued", 32'(memRead), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_memRead", 32'(memRead), 32'd0);
    check("abort_memWrite", 32'(memWrite), 32'd0);
    check("abort_respValid", 32'(respValid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_reqReady", 32'(reqReady), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_word_kept", mem_rd(30'h1FFFFFFC), 32'h80FF3344);

    // Sub-word stores (read-modify-write)
    issue(1, SIZE_HALF, 0, 32'h7FFFFFF2, 32'hAAAABEEF, 32'h0, 0, 4, 1, 1, 0);
    check("sh_word", mem_rd(30'h1FFFFFFC), 32'hBEEF3344);
    issue(0, SIZE_WORD, 0, 32'h7FFFFFF0, '0, 32'hBEEF3344, 0, 3, 1, 0, 0);
    issue(1, SIZE_BYTE, 0, 32'h7FFFFFF1, 32'h12345677, 32'h0, 0, 4, 1, 1, 0);
    check("sb1_word", mem_rd(30'h1FFFFFFC), 32'hBEEF7744);
    issue(1, SIZE_BYTE, 0, 32'h7FFFFFF3, 32'hFFFFFF01, 32'h0, 0, 4, 1, 1, 0);
    check("sb3_word", mem_rd(30'h1FFFFFFC), 32'h01EF7744);
    issue(0, SIZE_HALF, 0, 32'h7FFFFFF2, '0, 32'h000001EF, 0, 3, 1, 0, 0);

    // Word store with reqValid held while busy, then read back
    issue(1, SIZE_WORD, 0, 32'h7FFFFFF4, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 1);
    check("sw_word", mem_rd(30'h1FFFFFFD), 32'hDEADBEEF);
    issue(0, SIZE_WORD, 0, 32'h7FFFFFF4, '0, 32'hDEADBEEF, 0, 3, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
